// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared grid defaults, position type, food FSM states and LFSR taps
package snake_pkg;

    localparam int DEF_GRID_W = 160;
    localparam int DEF_GRID_H = 120;
    localparam int DEF_XW     = 8;
    localparam int DEF_YW     = 7;

    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [15:0] DEF_SEED     = 16'hACE1;

    typedef struct packed {
        logic [DEF_XW-1:0] x;
        logic [DEF_YW-1:0] y;
    } pos_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_QUERY,
        ST_CHECK,
        ST_DONE
    } food_state_e;

endpackage

// File: rtl/lfsr_galois.sv
// rtl/lfsr_galois.sv - free-running right-shift Galois LFSR with seed load and zero-seed guard
module lfsr_galois
    import snake_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_16),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (load) begin
            // An all-zero state would lock the register forever.
            q <= (load_val == '0) ? SEED : load_val;
        end else begin
            q <= (q >> 1) ^ (q[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/food_pos_gen.sv
// rtl/food_pos_gen.sv - draws random free playfield cells, checking each against the occupancy RAM
module food_pos_gen
    import snake_pkg::*;
#(
    parameter int                GRID_W    = DEF_GRID_W,
    parameter int                GRID_H    = DEF_GRID_H,
    parameter int                XW        = DEF_XW,
    parameter int                YW        = DEF_YW,
    parameter int                MIN_X     = 1,
    parameter int                MIN_Y     = 1,
    parameter int                MAX_X     = GRID_W - 1,
    parameter int                MAX_Y     = GRID_H - 1,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED),
    parameter int                MAX_TRIES = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              busy,
    output logic              valid,
    output logic              fail,
    output logic [XW-1:0]     pos_x,
    output logic [YW-1:0]     pos_y,
    output logic              occ_qvalid,
    output logic [XW-1:0]     occ_qx,
    output logic [YW-1:0]     occ_qy,
    input  logic              occ_hit
);

    localparam int            TW        = $clog2(MAX_TRIES + 1);
    localparam logic [XW-1:0] LO_X      = XW'(MIN_X);
    localparam logic [XW-1:0] HI_X      = XW'(MAX_X);
    localparam logic [YW-1:0] LO_Y      = YW'(MIN_Y);
    localparam logic [YW-1:0] HI_Y      = YW'(MAX_Y);
    localparam logic [TW-1:0] TRIES_LIM = TW'(MAX_TRIES);

    food_state_e       state, state_nx;
    logic [LFSR_W-1:0] lfsr_q;
    logic [TW-1:0]     tries, tries_nx;
    logic [XW-1:0]     cand_x, draw_x;
    logic [YW-1:0]     cand_y, draw_y;
    logic              draw_ok, pos_upd, fail_nx;

    lfsr_galois #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_W'(LFSR_TAPS_16)),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_load),
        .load_val (seed_in),
        .q        (lfsr_q)
    );

    assign draw_x  = lfsr_q[XW-1:0];
    assign draw_y  = lfsr_q[XW+YW-1:XW];
    assign draw_ok = (draw_x >= LO_X) && (draw_x <= HI_X) &&
                     (draw_y >= LO_Y) && (draw_y <= HI_Y);

    // LFSR bits above the coordinate field only feed the shift chain.
    if (LFSR_W > XW + YW) begin : g_spare
        logic unused_lfsr_hi;
        assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:XW+YW];
    end

    always_comb begin
        state_nx = state;
        tries_nx = tries;
        pos_upd  = 1'b0;
        fail_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nx = ST_DRAW;
                    tries_nx = '0;
                end
            end
            ST_DRAW: begin
                tries_nx = tries + TW'(1);
                if (draw_ok) begin
                    state_nx = ST_QUERY;
                end else if (tries_nx == TRIES_LIM) begin
                    state_nx = ST_DONE;
                    fail_nx  = 1'b1;
                end else begin
                    state_nx = ST_DRAW;
                end
            end
            ST_QUERY: state_nx = ST_CHECK;
            ST_CHECK: begin
                if (!occ_hit) begin
                    state_nx = ST_DONE;
                    pos_upd  = 1'b1;
                end else if (tries == TRIES_LIM) begin
                    state_nx = ST_DONE;
                    fail_nx  = 1'b1;
                end else begin
                    state_nx = ST_DRAW;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            tries  <= '0;
            cand_x <= '0;
            cand_y <= '0;
            pos_x  <= LO_X;
            pos_y  <= LO_Y;
            valid  <= 1'b0;
            fail   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state <= state_nx;
            tries <= tries_nx;
            if (state == ST_DRAW) begin
                cand_x <= draw_x;
                cand_y <= draw_y;
            end
            if (pos_upd) begin
                pos_x <= cand_x;
                pos_y <= cand_y;
            end
            valid <= (state_nx == ST_DONE);
            fail  <= fail_nx;
            busy  <= (state_nx != ST_IDLE);
        end
    end

    assign occ_qvalid = (state == ST_QUERY);
    assign occ_qx     = cand_x;
    assign occ_qy     = cand_y;

endmodule

// File: tb/tb_food_pos_gen.sv
// tb/tb_food_pos_gen.sv - scoreboard bench for food_pos_gen with randomized occupancy and seeds
module tb_food_pos_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst, req, seed_load, occ_hit;
    logic [15:0] seed_in;
    logic        busy, valid, fail, occ_qvalid;
    logic [7:0]  pos_x, occ_qx;
    logic [6:0]  pos_y, occ_qy;

    food_pos_gen dut (
        .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed_in(seed_in),
        .busy(busy), .valid(valid), .fail(fail), .pos_x(pos_x), .pos_y(pos_y),
        .occ_qvalid(occ_qvalid), .occ_qx(occ_qx), .occ_qy(occ_qy), .occ_hit(occ_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         fail;
        logic [7:0] x;
        logic [6:0] y;
        int         done_cyc;
        int         nq;
        int         q_base;
    } exp_t;

    int          total = 0, bad = 0;
    int          cyc = 0;
    exp_t        sbq[$];
    logic [14:0] pos_log[$];
    logic [14:0] log_a[$];
    bit          occ_map[32768];
    int          mode = 3;        // 0 map, 1 all occupied, 2 first query only, 3 all free
    int          q_cnt = 0, cur_q_base = 0;
    logic [7:0]  last_qx = '0, m_pos_x = 8'd1;
    logic [6:0]  last_qy = '0, m_pos_y = 7'd1;
    logic [15:0] m_lfsr;
    bit          pend = 1'b0, prev_valid = 1'b0;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        if (rst)            m_lfsr <= SEED;
        else if (seed_load) m_lfsr <= (seed_in == 16'h0) ? SEED : seed_in;
        else                m_lfsr <= step(m_lfsr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_occ(input logic [7:0] x, input logic [6:0] y, input int qi);
        case (mode)
            0:       return occ_map[{y, x}];
            1:       return 1'b1;
            2:       return qi == 1;
            default: return 1'b0;
        endcase
    endfunction

    // Walk the draw sequence from the value the LFSR holds in the first DRAW cycle.
    function automatic exp_t predict(input logic [15:0] draw_v, input int c0);
        exp_t       e;
        logic [15:0] v;
        logic [7:0] x;
        logic [6:0] y;
        int         t, nq;
        v = draw_v; t = c0 + 1; nq = 0;
        e.fail = 1'b1; e.x = m_pos_x; e.y = m_pos_y; e.done_cyc = 0; e.nq = 0; e.q_base = 0;
        for (int k = 1; k <= 31; k++) begin
            x = v[7:0];
            y = v[14:8];
            if (x >= 1 && x <= 159 && y >= 1 && y <= 119) begin
                nq++;
                if (!is_occ(x, y, nq)) begin
                    e.fail = 1'b0; e.x = x; e.y = y; e.done_cyc = t + 3; e.nq = nq;
                    return e;
                end
                if (k == 31) begin
                    e.done_cyc = t + 3; e.nq = nq;
                    return e;
                end
                t += 3;
                v = step(step(step(v)));
            end else begin
                if (k == 31) begin
                    e.done_cyc = t + 1; e.nq = nq;
                    return e;
                end
                t += 1;
                v = step(v);
            end
        end
        return e;
    endfunction

    // Occupancy RAM stand-in: answer one cycle after each query strobe.
    initial begin
        occ_hit = 1'b0;
        forever begin
            @(negedge clk);
            occ_hit = pend;
            if (occ_qvalid === 1'b1) begin
                q_cnt++;
                last_qx = occ_qx;
                last_qy = occ_qy;
                pend = is_occ(occ_qx, occ_qy, q_cnt - cur_q_base);
            end else begin
                pend = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (prev_valid) chk("busy_after_valid", busy, 0);
            if (fail === 1'b1) chk("fail_needs_valid", valid, 1);
            if (valid === 1'b1) begin
                chk("valid_expected", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    mon_e = sbq.pop_front();
                    chk("valid_cycle", cyc, mon_e.done_cyc);
                    chk("fail", fail, mon_e.fail);
                    chk("pos_x", pos_x, mon_e.x);
                    chk("pos_y", pos_y, mon_e.y);
                    chk("busy_at_valid", busy, 1);
                    chk("query_count", q_cnt - mon_e.q_base, mon_e.nq);
                    if (!mon_e.fail) begin
                        chk("query_x", last_qx, mon_e.x);
                        chk("query_y", last_qy, mon_e.y);
                        chk("pos_in_field", pos_x >= 1 && pos_x <= 159 && pos_y >= 1 && pos_y <= 119, 1);
                    end
                    pos_log.push_back({pos_x, pos_y});
                end
            end
            prev_valid = (valid === 1'b1);
        end
    end

    task automatic issue(input logic [15:0] draw_v, output int done_c);
        exp_t e;
        cur_q_base = q_cnt;
        e = predict(draw_v, cyc);
        e.q_base = q_cnt;
        sbq.push_back(e);
        if (!e.fail) begin
            m_pos_x = e.x;
            m_pos_y = e.y;
        end
        req = 1'b1;
        done_c = e.done_cyc;
    endtask

    // n requests with req held high so each is re-accepted right after DONE.
    task automatic run_seq(input int n, input bit do_seed, input logic [15:0] s);
        int          done_c;
        logic [15:0] dv;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == 0 && do_seed) begin
                seed_load = 1'b1;
                seed_in   = s;
                dv = (s == 16'h0) ? SEED : s;
            end else begin
                dv = step(m_lfsr);
            end
            issue(dv, done_c);
            @(negedge clk);
            seed_load = 1'b0;
            if (i == n - 1) req = 1'b0;
            while (cyc < done_c + 1) @(negedge clk);
        end
        chk("scoreboard_drained", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic fill_map(input int dens);
        for (int i = 0; i < 32768; i++) occ_map[i] = ($urandom_range(0, 99) < dens);
    endtask

    initial begin
        int done_c, c0;
        rst = 1'b1; req = 1'b0; seed_load = 1'b0; seed_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_lfsr", dut.u_lfsr.q, 16'hACE1);
        chk("rst_pos_x", pos_x, 1);
        chk("rst_pos_y", pos_y, 1);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_qvalid", occ_qvalid, 0);
        chk("rst_qx", occ_qx, 0);
        rst = 1'b0;

        // Exhaustion straight from reset: pos must stay at (1,1).
        mode = 1;
        run_seq(1, 1'b0, 16'h0);
        chk("exhaust_pos_x", pos_x, 1);
        chk("exhaust_pos_y", pos_y, 1);

        // Best case: seed 1234 gives an in-range first draw, valid 4 cycles after req.
        mode = 3;
        run_seq(1, 1'b1, 16'h1234);
        chk("best_pos_x", pos_x, 8'h34);
        chk("best_pos_y", pos_y, 7'h12);

        // Zero seed falls back to the default seed.
        @(negedge clk); seed_load = 1'b1; seed_in = 16'h0;
        @(negedge clk); seed_load = 1'b0;
        chk("zero_seed", dut.u_lfsr.q, 16'hACE1);

        // Same seed twice -> same position sequence.
        pos_log.delete();
        run_seq(3, 1'b1, 16'h1234);
        log_a = pos_log;
        pos_log.delete();
        repeat (5) @(negedge clk);
        run_seq(3, 1'b1, 16'h1234);
        chk("seed_rerun_len", pos_log.size(), 3);
        for (int i = 0; i < 3 && i < pos_log.size() && i < log_a.size(); i++)
            chk("seed_rerun_pos", pos_log[i], log_a[i]);

        // First query occupied, later draws free.
        mode = 2;
        run_seq(1, 1'b1, 16'h5A3C);
        run_seq(2, 1'b0, 16'h0);

        // req pulsed while busy must not start a second request.
        mode = 3;
        @(negedge clk);
        issue(step(m_lfsr), done_c);
        @(negedge clk); req = 1'b0;
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        while (cyc < done_c + 8) @(negedge clk);
        chk("busy_req_ignored", sbq.size(), 0);
        sbq.delete();

        // Reset during CHECK aborts the request.
        @(negedge clk);
        seed_load = 1'b1; seed_in = 16'h1234;
        c0 = cyc;
        issue(16'h1234, done_c);
        @(negedge clk); seed_load = 1'b0; req = 1'b0;
        while (cyc < c0 + 3) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        m_pos_x = 8'd1; m_pos_y = 7'd1;
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_pos_x", pos_x, 1);
        chk("abort_pos_y", pos_y, 1);
        chk("abort_busy", busy, 0);
        chk("abort_qvalid", occ_qvalid, 0);

        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 3);
            if (mode == 0) fill_map($urandom_range(10, 95));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_seq($urandom_range(1, 3), $urandom_range(0, 2) == 0,
                    ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
        end

        @(negedge clk);
        chk("lfsr_model", dut.u_lfsr.q, m_lfsr);
        repeat (4) @(negedge clk);
        chk("final_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
